// File: rtl/trace_step_loader.sv
// trace_step_loader: gathers one 18-word witness step into a collect buffer
// and hands it to decode as a registered bundle. The collect buffer and the
// output register form two slots, so step N+1 can be gathered while step N
// waits for decode. Each step header carries MAGIC and a running index; any
// header mismatch latches a sticky error that only reset clears.
//
// Handshake: a word moves on in_* only in a cycle where in_valid && in_ready,
// and a bundle moves on out_* only in a cycle where out_valid && out_ready.
// A raised valid, together with its data, holds until that transfer happens.
// in_ready is a register that follows the state alone. All out_* signals are
// registers, so there is no combinational path from in_* to out_*.
module trace_step_loader #(
  parameter logic [15:0] MAGIC = 16'h5354
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] raw_instr,
  output logic [31:0] eax,
  output logic [31:0] ebx,
  output logic [31:0] ecx,
  output logic [31:0] edx,
  output logic [31:0] esi,
  output logic [31:0] edi,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic        hint1_is_write,
  output logic [31:0] hint1_address,
  output logic [31:0] hint1_data,
  output logic        hint2_is_write,
  output logic [31:0] hint2_address,
  output logic [31:0] hint2_data,
  output logic [15:0] step_idx,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PENDING = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cbuf [18];   // collect buffer, indexed by word position
  logic [4:0]  wcnt;        // position of the next word within the step
  logic [15:0] exp_idx;     // index the next header must carry

  logic        accept;
  logic        hdr_ok;
  logic        last_word;
  logic        drain;
  logic        load;
  logic [31:0] w17;

  assign dbg_state = state;

  // Decide this cycle's transfers and whether a bundle moves into the output slot.
  always_comb begin
    accept    = in_valid && in_ready;
    hdr_ok    = (in_data[31:16] == MAGIC) && (in_data[15:0] == exp_idx);
    last_word = (wcnt == 5'd17);
    drain     = out_valid && out_ready;
    load      = 1'b0;
    if (state == COLLECT && accept && last_word && (!out_valid || out_ready))
      load = 1'b1;
    if (state == PENDING && drain)
      load = 1'b1;
    // On the fly the final word has not been written to the buffer yet.
    w17 = (state == COLLECT) ? in_data : cbuf[17];
  end

  // Control FSM, collect buffer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= COLLECT;
      in_ready       <= 1'b0;
      err            <= 1'b0;
      wcnt           <= 5'd0;
      exp_idx        <= 16'd0;
      out_valid      <= 1'b0;
      raw_instr      <= '0;
      eax            <= '0;
      ebx            <= '0;
      ecx            <= '0;
      edx            <= '0;
      esi            <= '0;
      edi            <= '0;
      esp            <= '0;
      ebp            <= '0;
      hint1_is_write <= 1'b0;
      hint1_address  <= '0;
      hint1_data     <= '0;
      hint2_is_write <= 1'b0;
      hint2_address  <= '0;
      hint2_data     <= '0;
      step_idx       <= '0;
      for (int i = 0; i < 18; i++) cbuf[i] <= '0;
    end else begin
      // Output slot: a new bundle wins over a drain in the same cycle.
      if (load) begin
        out_valid      <= 1'b1;
        raw_instr      <= {cbuf[3], cbuf[2], cbuf[1]};
        eax            <= cbuf[4];
        ebx            <= cbuf[5];
        ecx            <= cbuf[6];
        edx            <= cbuf[7];
        esi            <= cbuf[8];
        edi            <= cbuf[9];
        esp            <= cbuf[10];
        ebp            <= cbuf[11];
        hint1_is_write <= cbuf[12][0];
        hint1_address  <= cbuf[13];
        hint1_data     <= cbuf[14];
        hint2_is_write <= cbuf[15][0];
        hint2_address  <= cbuf[16];
        hint2_data     <= w17;
        step_idx       <= cbuf[0][15:0];
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (wcnt == 5'd0 && !hdr_ok) begin
              // Bad header: freeze collection; the partial step is dropped.
              state    <= ERROR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              cbuf[wcnt] <= in_data;
              if (wcnt == 5'd0) exp_idx <= exp_idx + 16'd1;
              if (last_word) begin
                wcnt <= 5'd0;
                if (!load) begin
                  state    <= PENDING;
                  in_ready <= 1'b0;
                end
              end else begin
                wcnt <= wcnt + 5'd1;
              end
            end
          end
        end
        PENDING: begin
          in_ready <= 1'b0;
          if (drain) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
          end
        end
        ERROR: begin
          in_ready <= 1'b0;
          err      <= 1'b1;
        end
        default: begin
          state    <= ERROR;
          in_ready <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_step_loader.sv
// Testbench for trace_step_loader: directed scenarios plus randomized step
// contents and handshake timing, checked against a step-level reference model.
module tb_trace_step_loader;

  localparam int BW = 498;  // flattened bundle width including step_idx
  localparam logic [15:0] MAGIC_TB = 16'h5354;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] raw_instr;
  logic [31:0] eax, ebx, ecx, edx, esi, edi, esp, ebp;
  logic        hint1_is_write, hint2_is_write;
  logic [31:0] hint1_address, hint1_data, hint2_address, hint2_data;
  logic [15:0] step_idx;
  logic        err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  logic rand_mode = 1'b0;
  logic ready_ctl = 1'b0;
  logic rand_bit  = 1'b0;
  assign out_ready = rand_mode ? rand_bit : ready_ctl;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  trace_step_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .raw_instr(raw_instr),
    .eax(eax), .ebx(ebx), .ecx(ecx), .edx(edx),
    .esi(esi), .edi(edi), .esp(esp), .ebp(ebp),
    .hint1_is_write(hint1_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_is_write(hint2_is_write), .hint2_address(hint2_address), .hint2_data(hint2_data),
    .step_idx(step_idx), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [15:0]   model_idx = 16'd0;   // header index the model expects next
  logic [31:0]   step_w [18];         // words of the step being sent
  int            gap_max = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] dut_bundle();
    return {raw_instr, eax, ebx, ecx, edx, esi, edi, esp, ebp,
            hint1_is_write, hint1_address, hint1_data,
            hint2_is_write, hint2_address, hint2_data, step_idx};
  endfunction

  // Reference: what decode should see for the step held in step_w.
  function automatic logic [BW-1:0] model_bundle();
    return {step_w[3], step_w[2], step_w[1],
            step_w[4], step_w[5], step_w[6], step_w[7],
            step_w[8], step_w[9], step_w[10], step_w[11],
            step_w[12][0], step_w[13], step_w[14],
            step_w[15][0], step_w[16], step_w[17],
            step_w[0][15:0]};
  endfunction

  // Output monitor: every transfer must match the oldest expected bundle,
  // and a held bundle must not change.
  logic          hold_prev = 1'b0;
  logic [BW-1:0] prev_b = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) chk("hold_stable", dut_bundle(), prev_b);
      if (out_valid && out_ready) begin
        chk("bundle_available", BW'(exp_q.size() > 0), BW'(1));
        if (exp_q.size() > 0) chk("bundle", dut_bundle(), exp_q.pop_front());
      end
      prev_b    = dut_bundle();
      hold_prev = out_valid && !out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d);
    int n;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", BW'(in_ready), BW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic fill_rand(input logic [15:0] idx);
    step_w[0] = {MAGIC_TB, idx};
    for (int i = 1; i < 18; i++) step_w[i] = $urandom;
  endtask

  // Sends words lo..hi of step_w; a completed step becomes an expected bundle.
  task automatic send_filled(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_word(step_w[i]);
    if (hi == 17) begin
      exp_q.push_back(model_bundle());
      model_idx = model_idx + 16'd1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_idx = 16'd0;
    #1;
    chk("rst_in_ready", BW'(in_ready), BW'(0));
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_err", BW'(err), BW'(0));
    chk("rst_bundle", dut_bundle(), BW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", BW'(in_ready), BW'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drained", BW'(exp_q.size()), BW'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset and the directed first step.
    do_reset();
    ready_ctl = 1'b1;
    step_w[0] = 32'h5354_0000;
    step_w[1] = 32'h1111_1111;
    step_w[2] = 32'h2222_2222;
    step_w[3] = 32'h3333_3333;
    for (int i = 0; i < 8; i++) step_w[4 + i] = 32'(i + 1);
    step_w[12] = 32'd1; step_w[13] = 32'h1000; step_w[14] = 32'hAA;
    step_w[15] = 32'd0; step_w[16] = 32'h2000; step_w[17] = 32'hBB;
    send_filled(0, 16);
    chk("t1_not_yet_valid", BW'(out_valid), BW'(0));
    send_filled(17, 17);
    chk("t1_out_valid", BW'(out_valid), BW'(1));
    chk("t1_raw_instr", BW'(raw_instr), BW'(96'h33333333_22222222_11111111));
    chk("t1_eax", BW'(eax), BW'(1));
    chk("t1_ebp", BW'(ebp), BW'(8));
    chk("t1_hint1_w", BW'(hint1_is_write), BW'(1));
    chk("t1_hint2_w", BW'(hint2_is_write), BW'(0));
    chk("t1_step_idx", BW'(step_idx), BW'(0));
    wait_drain();

    // Backpressure: one step held, the next parked, then a single-cycle drain.
    ready_ctl = 1'b0;
    fill_rand(model_idx); send_filled(0, 17);
    fill_rand(model_idx); send_filled(0, 17);
    chk("t2_pending_in_ready", BW'(in_ready), BW'(0));
    chk("t2_held_idx", BW'(step_idx), BW'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("t2_still_held", BW'(step_idx), BW'(1));
    chk("t2_still_pending", BW'(in_ready), BW'(0));
    ready_ctl = 1'b1;
    @(posedge clk);
    #1;
    ready_ctl = 1'b0;
    chk("t2_reload_valid", BW'(out_valid), BW'(1));
    chk("t2_reload_idx", BW'(step_idx), BW'(2));
    chk("t2_in_ready_back", BW'(in_ready), BW'(1));
    fill_rand(model_idx); send_filled(0, 17);
    chk("t2_third_pending", BW'(in_ready), BW'(0));
    ready_ctl = 1'b1;
    @(posedge clk);
    #1;
    ready_ctl = 1'b0;

    // Final word accepted in the same cycle the held bundle drains.
    fill_rand(model_idx);
    send_filled(0, 16);
    ready_ctl = 1'b1;
    send_filled(17, 17);
    chk("t3_no_bubble", BW'(out_valid), BW'(1));
    chk("t3_new_idx", BW'(step_idx), BW'(4));
    chk("t3_no_pending", BW'(in_ready), BW'(1));
    wait_drain();

    // Randomized steps with random input gaps and random out_ready.
    rand_mode = 1'b1;
    gap_max = 2;
    for (int s = 0; s < 6; s++) begin
      fill_rand(model_idx);
      send_filled(0, 17);
    end
    gap_max = 0;
    rand_mode = 1'b0;
    ready_ctl = 1'b1;
    wait_drain();
    chk("rand_no_err", BW'(err), BW'(0));

    // Bad magic while a bundle is held: the held bundle still drains.
    do_reset();
    ready_ctl = 1'b0;
    fill_rand(model_idx); send_filled(0, 17);
    chk("e1_err_before", BW'(err), BW'(0));
    send_word(32'hDEAD_0001);
    chk("e1_err", BW'(err), BW'(1));
    chk("e1_in_ready", BW'(in_ready), BW'(0));
    repeat (20) @(posedge clk);
    #1;
    chk("e1_err_sticky", BW'(err), BW'(1));
    chk("e1_in_ready_stuck", BW'(in_ready), BW'(0));
    ready_ctl = 1'b1;
    wait_drain();
    chk("e1_out_empty", BW'(out_valid), BW'(0));

    // Wrong index right after reset.
    do_reset();
    send_word(32'h5354_0005);
    chk("e2_err", BW'(err), BW'(1));
    chk("e2_in_ready", BW'(in_ready), BW'(0));
    chk("e2_out_valid", BW'(out_valid), BW'(0));

    // Wrong magic with the right index right after reset.
    do_reset();
    send_word(32'hDEAD_0000);
    chk("e3_err", BW'(err), BW'(1));
    chk("e3_in_ready", BW'(in_ready), BW'(0));

    // Index counter wrap FFFF -> 0000.
    do_reset();
    @(negedge clk);
    force dut.exp_idx = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.exp_idx;
    model_idx = 16'hFFFF;
    ready_ctl = 1'b1;
    fill_rand(model_idx); send_filled(0, 17);
    chk("w_ffff_ok", BW'(err), BW'(0));
    fill_rand(model_idx); send_filled(0, 17);
    chk("w_0000_ok", BW'(err), BW'(0));
    chk("w_model_wrapped", BW'(model_idx), BW'(16'h0001));
    wait_drain();

    // Reset in the middle of a step while a bundle is held.
    do_reset();
    ready_ctl = 1'b0;
    fill_rand(model_idx); send_filled(0, 17);
    fill_rand(model_idx); send_filled(0, 8);
    chk("m_held_before_rst", BW'(out_valid), BW'(1));
    do_reset();
    ready_ctl = 1'b1;
    fill_rand(16'd0); send_filled(0, 17);
    chk("m_header0_ok", BW'(err), BW'(0));
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    chk("end_queue_empty", BW'(exp_q.size()), BW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
